// File: rtl/nn_ctrl_pkg.sv
// Shared types and helpers for the neuron control path.
// Holds the sequencer state encoding and counter width helper.
package nn_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        ACCUM  = 3'd2,
        RESULT = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Width of a counter over x values, never narrower than one bit.
    function automatic int cw(input int x);
        return (x > 1) ? $clog2(x) : 1;
    endfunction

endpackage

// File: rtl/step_counter.sv
// Modulo-MOD up counter with synchronous clear and enable.
// o_tc flags the last count; an enabled step there wraps to zero.
module step_counter
    import nn_ctrl_pkg::*;
#(
    parameter int MOD = 10,
    parameter int W   = cw(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    assign o_count = r_count;
    assign o_tc    = (r_count == W'(MOD - 1));

    // Count register: clear wins over enable, wrap at terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_tc ? '0 : r_count + W'(1);
        end
    end

endmodule

// File: rtl/mac_sequencer.sv
// Layer sequencer driving the neuron MAC datapath controls.
// Every output comes straight from a flop (Moore outputs).
module mac_sequencer
    import nn_ctrl_pkg::*;
#(
    parameter int N  = 10,
    parameter int M  = 10,
    parameter int OW = cw(N),
    parameter int NW = cw(M)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          hidden_in,
    input  logic          out_ack,
    output logic          acc_clr,
    output logic          ld,
    output logic [OW-1:0] offset,
    output logic          ready,
    output logic          hidden,
    output logic [NW-1:0] neuron_idx,
    output logic          busy,
    output logic          layer_done
);

    state_t r_state;
    state_t w_next;

    logic r_acc_clr;
    logic r_ld;
    logic r_ready;
    logic r_hidden;
    logic r_busy;
    logic r_done;

    logic          w_off_tc;
    logic          w_idx_tc;
    logic          w_start_ok;
    logic          w_idx_en;
    logic [OW-1:0] w_off;
    logic [NW-1:0] w_idx;

    assign w_start_ok = (r_state == IDLE) && start;
    assign w_idx_en   = (r_state == RESULT) && out_ack && !w_idx_tc;

    // Offset only runs inside ACCUM; its wrap coincides with leaving it.
    step_counter #(.MOD(N), .W(OW)) u_off (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (r_state != ACCUM),
        .i_en    (r_state == ACCUM),
        .o_count (w_off),
        .o_tc    (w_off_tc)
    );

    step_counter #(.MOD(M), .W(NW)) u_idx (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_start_ok),
        .i_en    (w_idx_en),
        .o_count (w_idx),
        .o_tc    (w_idx_tc)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) w_next = CLEAR;
            end
            CLEAR: begin
                w_next = ACCUM;
            end
            ACCUM: begin
                if (w_off_tc) w_next = RESULT;
            end
            RESULT: begin
                if (out_ack) w_next = w_idx_tc ? DONE : CLEAR;
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Output flops track the state being entered, so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_clr <= 1'b0;
            r_ld      <= 1'b0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hidden  <= 1'b0;
        end else begin
            r_acc_clr <= (w_next == CLEAR);
            r_ld      <= (w_next == ACCUM);
            r_ready   <= (w_next == RESULT);
            r_busy    <= (w_next != IDLE);
            r_done    <= (w_next == DONE);
            if (w_start_ok) r_hidden <= hidden_in;
        end
    end

    assign acc_clr    = r_acc_clr;
    assign ld         = r_ld;
    assign offset     = w_off;
    assign ready      = r_ready;
    assign hidden     = r_hidden;
    assign neuron_idx = w_idx;
    assign busy       = r_busy;
    assign layer_done = r_done;

endmodule
